alu_mul_sequencer: RTL

- Sequencing controller wrapped around one instance of the team's 16-bit control-bit ALU (`alu`: o, zr, ng, x, y, zx, nx, zy, ny, f, no).
- Accepts commands over a valid/ready interface:
  - single-op mode: one ALU pass using a caller-supplied 6-bit control word.
  - multiply mode: 16x16 low-half product computed by iterated add/double through the same ALU.
- Result and flags are held behind an output valid/ready handshake.
- Sits between the register/operand logic and the ALU as its sole owner.

---
 rtl/alu_mul_sequencer.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/alu_mul_sequencer.sv
// Sequencing controller around the 16-bit control-bit ALU: single ALU pass or
// shift-and-add low-half multiply, with valid/ready on both sides.

module alu (
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic        zx,
    input  logic        nx,
    input  logic        zy,
    input  logic        ny,
    input  logic        f,
    input  logic        no,
    output logic [15:0] o,
    output logic        zr,
    output logic        ng
);
    logic [15:0] x1, x2, y1, y2, fo;

    always_comb begin
        x1 = zx ? '0 : x;
        x2 = nx ? ~x1 : x1;
        y1 = zy ? '0 : y;
        y2 = ny ? ~y1 : y1;
        fo = f ? (x2 + y2) : (x2 & y2);
        o  = no ? ~fo : fo;
        zr = (o == '0);
        ng = o[15];
    end
endmodule

module alu_mul_sequencer #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned EARLY_EXIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mul,
    input  logic [5:0]       in_f,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             res_zr,
    output logic             res_ng,
    output logic             busy
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {IDLE, OP, ADD, DBL, DONE} state_t;

    state_t           state_q, state_d;
    logic [5:0]       f_q, f_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zr_q, zr_d;
    logic             ng_q, ng_d;
    logic             out_valid_q, out_valid_d;

    logic [WIDTH-1:0] alu_x, alu_y, alu_o;
    logic [5:0]       alu_f;
    logic             alu_zr, alu_ng;
    logic             mul_done;

    alu u_alu (
        .x  (alu_x),
        .y  (alu_y),
        .zx (alu_f[5]),
        .nx (alu_f[4]),
        .zy (alu_f[3]),
        .ny (alu_f[2]),
        .f  (alu_f[1]),
        .no (alu_f[0]),
        .o  (alu_o),
        .zr (alu_zr),
        .ng (alu_ng)
    );

    always_comb begin
        state_d     = state_q;
        f_d         = f_q;
        acc_d       = acc_q;
        m_d         = m_q;
        b_d         = b_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        zr_d        = zr_q;
        ng_d        = ng_q;
        out_valid_d = out_valid_q;
        alu_x       = '0;
        alu_y       = '0;
        alu_f       = 6'b101010;
        mul_done    = ((EARLY_EXIT != 0) && (b_q == '0)) || (cnt_q == CW'(WIDTH));

        case (state_q)
            IDLE: begin
                // m/b double as the latched x/y operands for a single op
                if (in_valid) begin
                    f_d     = in_f;
                    m_d     = in_x;
                    b_d     = in_y;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = in_mul ? ADD : OP;
                end
            end
            OP: begin
                alu_x       = m_q;
                alu_y       = b_q;
                alu_f       = f_q;
                result_d    = alu_o;
                zr_d        = alu_zr;
                ng_d        = alu_ng;
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            ADD: begin
                if (mul_done) begin
                    result_d    = acc_q;
                    zr_d        = (acc_q == '0);
                    ng_d        = acc_q[WIDTH-1];
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    alu_x = acc_q;
                    alu_y = m_q;
                    alu_f = 6'b000010;
                    if (b_q[0]) begin
                        acc_d = alu_o;
                    end
                    state_d = DBL;
                end
            end
            DBL: begin
                alu_x   = m_q;
                alu_y   = m_q;
                alu_f   = 6'b000010;
                m_d     = alu_o;
                b_d     = b_q >> 1;
                cnt_d   = cnt_q + CW'(1);
                state_d = ADD;
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            f_q         <= '0;
            acc_q       <= '0;
            m_q         <= '0;
            b_q         <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            zr_q        <= 1'b0;
            ng_q        <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            f_q         <= f_d;
            acc_q       <= acc_d;
            m_q         <= m_d;
            b_q         <= b_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            zr_q        <= zr_d;
            ng_q        <= ng_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == IDLE) && !rst;
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign res_zr    = zr_q;
    assign res_ng    = ng_q;
endmodule
